// File: rtl/cs5361_sample_fifo.sv
// cs5361_sample_fifo
// Sits after the cs5361 serial receiver. Each rising edge of adcstrobe
// captures one sample into a circular FIFO. The FIFO is read through a
// show-ahead valid/ready port. The block also flags dropped samples and
// tracks a slowly decaying peak magnitude for a signal-present indicator.
//
// Pointers and fill are all registered. Because of that, rd_valid and
// rd_data only change on a clock edge. There is no combinational path
// from adcstrobe or rd_ready to rd_valid.
module cs5361_sample_fifo #(
  parameter int AW        = 4,
  parameter int DECAY_DIV = 4096
) (
  input  logic          mclk,
  input  logic          rst_,
  input  logic [7:0]    adcval,
  input  logic          adcstrobe,
  output logic [7:0]    rd_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [AW:0]   fill,
  output logic          ovfl,
  input  logic          clr_ovfl,
  output logic [6:0]    level
);

  localparam int DEPTH = 2**AW;
  localparam int DW    = $clog2(DECAY_DIV);

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   FILL_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [DW-1:0] DCNT_MAX = DW'(DECAY_DIV - 1);
  localparam logic [DW-1:0] DCNT_ONE = DW'(1);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_fill;
  logic          r_ovfl;
  logic          r_stb_d;
  logic [6:0]    r_level;
  logic [DW-1:0] r_dcnt;

  logic          w_cap;
  logic          w_full;
  logic          w_empty;
  logic          w_rd;
  logic          w_wr;
  logic          w_drop;
  logic          w_tick;
  logic [6:0]    w_neg;
  logic [6:0]    w_mag;
  logic [6:0]    w_dec;

  assign w_cap   = adcstrobe & ~r_stb_d;
  assign w_full  = (r_fill == FULL_CNT);
  assign w_empty = (r_fill == '0);
  assign w_rd    = ~w_empty & rd_ready;
  // When the FIFO is full, a simultaneous read frees a slot in the same
  // cycle, so the new sample is still accepted.
  assign w_wr    = w_cap & (~w_full | w_rd);
  assign w_drop  = w_cap & w_full & ~w_rd;
  assign w_tick  = (r_dcnt == DCNT_MAX);

  assign w_neg   = ~adcval[6:0] + 7'd1;
  assign w_dec   = (w_tick && r_level != 7'd0) ? r_level - 7'd1 : r_level;

  // Magnitude of the two's-complement sample. -128 has no positive
  // 8-bit counterpart, so it saturates to 127.
  always_comb begin
    w_mag = adcval[6:0];
    if (adcval[7]) begin
      if (adcval == 8'h80) w_mag = 7'd127;
      else                 w_mag = w_neg;
    end
  end

  assign rd_valid = ~w_empty;
  assign rd_data  = r_mem[r_rd_ptr];
  assign fill     = r_fill;
  assign ovfl     = r_ovfl;
  assign level    = r_level;

  // Sample storage. The memory is intentionally not reset.
  always_ff @(posedge mclk) begin
    if (w_wr) r_mem[r_wr_ptr] <= adcval;
  end

  // Strobe edge detector, write/read pointers and fill count.
  always_ff @(posedge mclk or negedge rst_) begin
    if (!rst_) begin
      r_stb_d  <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else begin
      r_stb_d <= adcstrobe;
      if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_wr, w_rd})
        2'b10:   r_fill <= r_fill + FILL_ONE;
        2'b01:   r_fill <= r_fill - FILL_ONE;
        default: r_fill <= r_fill;
      endcase
    end
  end

  // Sticky overflow flag. A drop in the same cycle as clr_ovfl wins.
  always_ff @(posedge mclk or negedge rst_) begin
    if (!rst_)         r_ovfl <= 1'b0;
    else if (w_drop)   r_ovfl <= 1'b1;
    else if (clr_ovfl) r_ovfl <= 1'b0;
  end

  // Free-running decay timer and peak-level tracker. The level is updated
  // even when the sample itself is dropped because the FIFO was full.
  always_ff @(posedge mclk or negedge rst_) begin
    if (!rst_) begin
      r_dcnt  <= '0;
      r_level <= 7'd0;
    end else begin
      r_dcnt <= w_tick ? '0 : r_dcnt + DCNT_ONE;
      if (w_cap && w_mag > w_dec) r_level <= w_mag;
      else                        r_level <= w_dec;
    end
  end

endmodule

// File: tb/tb_cs5361_sample_fifo.sv
// Directed bench for cs5361_sample_fifo. The DUT uses AW=4 and DECAY_DIV=4.
module tb_cs5361_sample_fifo;

  logic       mclk = 1'b0;
  logic       rst_ = 1'b0;
  logic [7:0] adcval = 8'h00;
  logic       adcstrobe = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready = 1'b0;
  logic [4:0] fill;
  logic       ovfl;
  logic       clr_ovfl = 1'b0;
  logic [6:0] level;

  int n_checks = 0;
  int n_fail   = 0;

  cs5361_sample_fifo #(.AW(4), .DECAY_DIV(4)) u_dut (
    .mclk      (mclk),
    .rst_      (rst_),
    .adcval    (adcval),
    .adcstrobe (adcstrobe),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .fill      (fill),
    .ovfl      (ovfl),
    .clr_ovfl  (clr_ovfl),
    .level     (level)
  );

  always #5 mclk = ~mclk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Advance one edge, then settle 1 ns past it.
  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  // Single-cycle strobe followed by one idle cycle.
  task automatic pulse(input logic [7:0] v);
    adcval = v;
    adcstrobe = 1'b1;
    step();
    adcstrobe = 1'b0;
    step();
  endtask

  int lvl_prev;
  int t_now;
  int t_last;
  int bad_step;
  int got126;
  int n_rd;
  int max_fill;
  int bad_order;
  int gap;

  initial begin
    // Reset state
    #12;
    chk("rst_fill", fill, 0);
    chk("rst_valid", rd_valid, 0);
    chk("rst_ovfl", ovfl, 0);
    chk("rst_level", level, 0);
    @(negedge mclk);
    rst_ = 1'b1;

    // 1: a 3-cycle strobe captures exactly once
    step();
    adcval = 8'h25;
    adcstrobe = 1'b1;
    step();
    chk("t1_fill_T1", fill, 1);
    chk("t1_valid_T1", rd_valid, 1);
    chk("t1_data", rd_data, 8'h25);
    chk("t1_level", level, 37);
    step();
    step();
    adcstrobe = 1'b0;
    step();
    chk("t1_fill_hold", fill, 1);
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    chk("t1_drained", rd_valid, 0);
    // rd_ready while the FIFO is empty must be ignored
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    chk("t1_empty_rd_fill", fill, 0);

    // 2: 17 strobes overflow a 16-entry FIFO
    for (int i = 1; i <= 16; i++) pulse(8'(i));
    chk("t2_fill16", fill, 16);
    chk("t2_ovfl_pre", ovfl, 0);
    pulse(8'd17);
    chk("t2_fill_after17", fill, 16);
    chk("t2_ovfl", ovfl, 1);
    rd_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      chk($sformatf("t2_rd%0d", i), rd_data, i);
      step();
    end
    rd_ready = 1'b0;
    chk("t2_empty", rd_valid, 0);
    chk("t2_ovfl_sticky", ovfl, 1);
    clr_ovfl = 1'b1;
    step();
    clr_ovfl = 1'b0;
    chk("t2_ovfl_clr", ovfl, 0);

    // 3: full FIFO, capture coincides with a read
    for (int i = 0; i < 16; i++) pulse(8'(8'h40 + i));
    chk("t3_fill16", fill, 16);
    adcval = 8'h50;
    adcstrobe = 1'b1;
    rd_ready = 1'b1;
    chk("t3_oldest", rd_data, 8'h40);
    step();
    adcstrobe = 1'b0;
    rd_ready = 1'b0;
    chk("t3_fill_stays", fill, 16);
    step();
    chk("t3_no_ovfl", ovfl, 0);
    rd_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      chk($sformatf("t3_rd%0d", i), rd_data, 8'h40 + i);
      step();
    end
    rd_ready = 1'b0;
    chk("t3_empty", rd_valid, 0);

    // 4: streaming with rd_ready held high, 40 samples, pointers wrap twice
    rd_ready = 1'b1;
    n_rd = 0;
    max_fill = 0;
    bad_order = 0;
    for (int s = 0; s < 40; s++) begin
      for (int c = 0; c < 8; c++) begin
        adcval = 8'(s + 3);
        adcstrobe = (c == 0);
        if (rd_valid) begin
          if (rd_data != 8'(n_rd + 3)) bad_order++;
          n_rd++;
        end
        step();
        if (fill > max_fill) max_fill = fill;
      end
    end
    adcstrobe = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (rd_valid) begin
        if (rd_data != 8'(n_rd + 3)) bad_order++;
        n_rd++;
      end
      step();
    end
    chk("t4_reads", n_rd, 40);
    chk("t4_order_errs", bad_order, 0);
    chk("t4_max_fill", max_fill, 1);
    chk("t4_empty", rd_valid, 0);

    // 5: -128 saturates to 127, then the level decays by 1 every 4 cycles
    adcval = 8'h80;
    adcstrobe = 1'b1;
    step();
    adcstrobe = 1'b0;
    chk("t5_level127", level, 127);
    got126 = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (level == 126) got126 = 1;
    end
    chk("t5_reach126", got126, 1);
    // Measure the spacing of the next decrements
    lvl_prev = level;
    t_now = 0;
    t_last = -1;
    bad_step = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      t_now++;
      if (level != lvl_prev) begin
        if (level != lvl_prev - 1) bad_step++;
        if (t_last >= 0) begin
          gap = t_now - t_last;
          chk("t5_gap", gap, 4);
        end
        t_last = t_now;
        lvl_prev = level;
      end
    end
    chk("t5_bad_steps", bad_step, 0);
    for (int c = 0; c < 600; c++) step();
    chk("t5_floor", level, 0);
    rd_ready = 1'b0;
    chk("t5_fifo_empty", rd_valid, 0);

    // 6: asynchronous reset with fill=5 and ovfl=1
    for (int i = 0; i < 17; i++) pulse(8'(8'h70 + i));
    rd_ready = 1'b1;
    for (int i = 0; i < 11; i++) step();
    rd_ready = 1'b0;
    chk("t6_fill5", fill, 5);
    chk("t6_ovfl1", ovfl, 1);
    @(posedge mclk);
    #2;
    rst_ = 1'b0;
    #1;
    chk("t6_async_fill", fill, 0);
    chk("t6_async_valid", rd_valid, 0);
    chk("t6_async_ovfl", ovfl, 0);
    chk("t6_async_level", level, 0);
    @(negedge mclk);
    rst_ = 1'b1;
    pulse(8'h33);
    chk("t6_resume_fill", fill, 1);
    chk("t6_resume_data", rd_data, 8'h33);
    chk("t6_resume_level", level, 51);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Watchdog that stops a stalled run.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
